video_sel_ctrl: RTL

Frame-synchronous source-select controller for the video datapath. Arbitrates between two requesters, such as host register port and test sequencer, that want to change the video source select (bars / colour). Applies the change only at the start of vertical blanking, so no partial frame is emitted. Also tracks raster position from the fvht timing bus and exports the pixel and line counts.

---
 rtl/video_pkg.sv | 23 ++
 rtl/video_raster_cnt.sv | 65 ++++++
 rtl/video_sel_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: FVHT bit positions, source select encoding,
// selector FSM states and the default raster counter width.
package video_pkg;

  localparam int F_BIT = 3;
  localparam int V_BIT = 2;
  localparam int H_BIT = 1;
  localparam int T_BIT = 0;

  localparam int CNT_W_DEF = 11;

  typedef enum logic {
    SRC_BARS   = 1'b0,
    SRC_COLOUR = 1'b1
  } vid_src_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ACK   = 2'd2
  } sel_state_t;

endpackage

// File: rtl/video_raster_cnt.sv
// Raster position tracker: H-fall / V-rise detection on the fvht bus plus
// saturating pixel and line counters. Shared by select, mask and overlay blocks.
module video_raster_cnt
  import video_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cen_i,
  input  logic [3:0]       fvht_i,
  output logic             v_rise_o,
  output logic             h_fall_o,
  output logic [CNT_W-1:0] pix_count_o,
  output logic [CNT_W-1:0] line_count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             v_q, v_d;
  logic             h_q, h_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic             unused_ft;

  assign unused_ft = ^{fvht_i[F_BIT], fvht_i[T_BIT]};

  // NOTE: every variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    v_d      = v_q;
    h_d      = h_q;
    pix_d    = pix_q;
    line_d   = line_q;
    v_rise_o = cen_i & fvht_i[V_BIT] & ~v_q;
    h_fall_o = cen_i & ~fvht_i[H_BIT] & h_q;
    if (cen_i) begin
      v_d = fvht_i[V_BIT];
      h_d = fvht_i[H_BIT];
      if (h_fall_o)              pix_d = '0;
      else if (pix_q != CNT_MAX) pix_d = pix_q + CNT_W'(1);
      // A frame start overrides the line advance of a coincident H fall.
      if (v_rise_o)                          line_d = CNT_W'(1);
      else if (h_fall_o && line_q != CNT_MAX) line_d = line_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v_q    <= 1'b0;
      h_q    <= 1'b0;
      pix_q  <= '0;
      line_q <= '0;
    end else begin
      v_q    <= v_d;
      h_q    <= h_d;
      pix_q  <= pix_d;
      line_q <= line_d;
    end
  end

  assign pix_count_o  = pix_q;
  assign line_count_o = line_q;

endmodule

// File: rtl/video_sel_ctrl.sv
// Frame-synchronous source-select controller: round-robin between two
// requesters, switch applied on V rise. Watchdog built with VIDEO_SEL_WDOG_EN.
module video_sel_ctrl
  import video_pkg::*;
#(
  parameter int WDOG_CYCLES = 4194304,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cen_i,
  input  logic [3:0]       fvht_i,
  input  logic [1:0]       req_i,
  input  logic [1:0]       sel_req_i,
  output logic [1:0]       ack_o,
  output logic             vid_sel_o,
  output logic             pending_o,
  output logic             wdog_err_o,
  output logic [CNT_W-1:0] pix_count_o,
  output logic [CNT_W-1:0] line_count_o
);

  if (WDOG_CYCLES < 1) begin : g_wdog_cycles_invalid
    $error("WDOG_CYCLES must be positive");
  end

  sel_state_t state_q, state_d;
  vid_src_t   vid_sel_q, vid_sel_d;
  logic       grant_q, grant_d;
  logic       rr_q, rr_d;
  logic [1:0] ack_q, ack_d;
  logic [1:0] req_eff;
  logic       winner;
  logic       v_rise;
  logic       unused_h_fall;
  logic       wdog_fire;

  video_raster_cnt #(.CNT_W(CNT_W)) u_raster (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .cen_i        (cen_i),
    .fvht_i       (fvht_i),
    .v_rise_o     (v_rise),
    .h_fall_o     (unused_h_fall),
    .pix_count_o  (pix_count_o),
    .line_count_o (line_count_o)
  );

`ifdef VIDEO_SEL_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;

  always_comb begin
    wdog_fire  = cen_i && (state_q == ST_ARMED) &&
                 (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));
    wdog_cnt_d = wdog_cnt_q;
    wdog_err_d = wdog_err_q;
    if (cen_i) begin
      wdog_cnt_d = (state_q == ST_ARMED && !wdog_fire) ? wdog_cnt_q + WDOG_W'(1) : '0;
      // Only a switch that actually happened because of the timeout is flagged.
      if (wdog_fire && req_i[grant_q] && !v_rise) wdog_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err_o = wdog_err_q;
`else
  assign wdog_fire  = 1'b0;
  assign wdog_err_o = 1'b0;
`endif

  // A requester still seeing its ack is ignored, so a level request is not re-served.
  always_comb begin
    req_eff = req_i & ~ack_q;
    if (req_eff == 2'b11) winner = rr_q;
    else                  winner = req_eff[1];
  end

  always_comb begin
    state_d   = state_q;
    vid_sel_d = vid_sel_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    ack_d     = ack_q;
    if (cen_i) begin
      ack_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (|req_eff) begin
            grant_d = winner;
            state_d = (sel_req_i[winner] == vid_sel_q) ? ST_ACK : ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (!req_i[grant_q]) begin
            state_d = ST_IDLE;
          end else if (v_rise || wdog_fire) begin
            vid_sel_d = vid_src_t'(sel_req_i[grant_q]);
            state_d   = ST_ACK;
          end
        end
        ST_ACK: begin
          ack_d[grant_q] = 1'b1;
          rr_d           = ~grant_q;
          state_d        = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      vid_sel_q <= SRC_BARS;
      grant_q   <= 1'b0;
      rr_q      <= 1'b0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      vid_sel_q <= vid_sel_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      ack_q     <= ack_d;
    end
  end

  assign ack_o     = ack_q;
  assign vid_sel_o = vid_sel_q;
  assign pending_o = (state_q == ST_ARMED);

endmodule
